// File: rtl/wf_fetch_sched.sv
// Round-robin wavefront instruction-fetch scheduler with per-slot PC, epoch and outstanding-request tracking.
// Define WF_FETCH_DUAL_OUTSTANDING_EN to allow two outstanding fetches per slot (default: one).
`timescale 1ns/1ps
module wf_fetch_sched #(
    parameter int NUM_WF      = 40,
    parameter int WFID_W      = 6,
    parameter int PC_W        = 32,
    parameter int FETCH_BYTES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_wr,
    input  logic [WFID_W-1:0] init_wfid,
    input  logic [PC_W-1:0]   init_pc,
    input  logic              branch_en,
    input  logic [WFID_W-1:0] branch_wfid,
    input  logic [PC_W-1:0]   branch_pc,
    input  logic              recover_en,
    input  logic [WFID_W-1:0] recover_wfid,
    input  logic [PC_W-1:0]   recover_pc,
    input  logic              done_en,
    input  logic [WFID_W-1:0] done_wfid,
    input  logic [NUM_WF-1:0] stop_fetch,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [PC_W-1:0]   req_addr,
    output logic [WFID_W:0]   req_tag,
    input  logic              ack_valid,
    input  logic [WFID_W-1:0] ack_wfid,
    output logic [NUM_WF-1:0] vacant,
    output logic              free_valid,
    output logic [WFID_W-1:0] free_wfid,
    output logic [NUM_WF-1:0] pending
);

`ifdef WF_FETCH_DUAL_OUTSTANDING_EN
    localparam int CNT_W  = 2;
    localparam int MAXOUT = 2;
`else
    localparam int CNT_W  = 1;
    localparam int MAXOUT = 1;
`endif

    logic [NUM_WF-1:0] valid_q, valid_d;
    logic [NUM_WF-1:0] epoch_q, epoch_d;
    logic [PC_W-1:0]   pc_q  [NUM_WF];
    logic [PC_W-1:0]   pc_d  [NUM_WF];
    logic [CNT_W-1:0]  cnt_q [NUM_WF];
    logic [CNT_W-1:0]  cnt_d [NUM_WF];
    logic [WFID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [NUM_WF-1:0] done_hit;
    logic [NUM_WF-1:0] elig;
    logic [WFID_W-1:0] grant;
    logic              found;
    logic              xfer;

    always_comb begin
        for (int i = 0; i < NUM_WF; i++) begin
            done_hit[i] = done_en && (done_wfid == WFID_W'(i));
            elig[i]     = valid_q[i] && !stop_fetch[i] && !done_hit[i] &&
                          (cnt_q[i] < CNT_W'(MAXOUT));
        end
    end

    // Scan starts at rr_ptr and wraps; rr_ptr is always kept below NUM_WF.
    always_comb begin : grant_scan
        int idx;
        idx   = 0;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_WF; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_WF) begin
                idx = idx - NUM_WF;
            end
            if (!found && elig[idx]) begin
                found = 1'b1;
                grant = WFID_W'(idx);
            end
        end
    end

    always_comb begin
        req_valid = found;
        xfer      = found && req_ready;
        req_addr  = found ? pc_q[grant] : '0;
        req_tag   = found ? {epoch_q[grant], grant} : '0;
    end

    always_comb begin
        logic hit_init, hit_br, hit_rc, xfer_i, ack_i;
        hit_init = 1'b0;
        hit_br   = 1'b0;
        hit_rc   = 1'b0;
        xfer_i   = 1'b0;
        ack_i    = 1'b0;
        valid_d  = valid_q;
        epoch_d  = epoch_q;
        for (int i = 0; i < NUM_WF; i++) begin
            pc_d[i]  = pc_q[i];
            cnt_d[i] = cnt_q[i];
            hit_rc   = recover_en && (recover_wfid == WFID_W'(i)) && valid_q[i];
            hit_br   = branch_en && (branch_wfid == WFID_W'(i)) && valid_q[i];
            xfer_i   = xfer && (grant == WFID_W'(i));
            ack_i    = ack_valid && (ack_wfid == WFID_W'(i)) && (cnt_q[i] != '0);
            hit_init = init_wr && (init_wfid == WFID_W'(i)) && !valid_q[i] &&
                       (cnt_q[i] == '0) && !done_hit[i];

            if (xfer_i && !ack_i) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (ack_i && !xfer_i) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end

            // Recover beats branch beats the fetch increment; epoch flips once.
            if (hit_rc) begin
                pc_d[i] = recover_pc;
            end else if (hit_br) begin
                pc_d[i] = branch_pc;
            end else if (xfer_i) begin
                pc_d[i] = pc_q[i] + PC_W'(FETCH_BYTES);
            end
            if (hit_rc || hit_br) begin
                epoch_d[i] = ~epoch_q[i];
            end

            if (done_hit[i]) begin
                valid_d[i] = 1'b0;
            end
            if (hit_init) begin
                valid_d[i] = 1'b1;
                pc_d[i]    = init_pc;
                epoch_d[i] = 1'b0;
                cnt_d[i]   = '0;
            end
        end

        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = (grant == WFID_W'(NUM_WF - 1)) ? '0 : grant + 1'b1;
        end
    end

    always_comb begin
        free_valid = 1'b0;
        free_wfid  = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            vacant[i]  = !valid_q[i] && (cnt_q[i] == '0);
            pending[i] = (cnt_q[i] != '0);
        end
        for (int i = NUM_WF - 1; i >= 0; i--) begin
            if (vacant[i]) begin
                free_valid = 1'b1;
                free_wfid  = WFID_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= '0;
            epoch_q  <= '0;
            rr_ptr_q <= '0;
            for (int i = 0; i < NUM_WF; i++) begin
                pc_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            epoch_q  <= epoch_d;
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < NUM_WF; i++) begin
                pc_q[i]  <= pc_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: doc/wf_fetch_sched.md
WF_FETCH_SCHED -- requirements
Module: wf_fetch_sched

Interface
REQ-001 Parameter NUM_WF, default 40: number of wavefront slots, 2..64.
REQ-002 Parameter WFID_W, default 6: wavefront-id width; 2^WFID_W >= NUM_WF.
REQ-003 Parameter PC_W, default 32: program-counter width.
REQ-004 Parameter FETCH_BYTES, default 32: PC advance per accepted fetch; power of two.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous assert, active-low.
REQ-007 init_wr  in  1, init_wfid  in  WFID_W, init_pc  in  PC_W: allocate a slot and set its start PC.
REQ-008 branch_en  in  1, branch_wfid  in  WFID_W, branch_pc  in  PC_W: taken-branch redirect.
REQ-009 recover_en  in  1, recover_wfid  in  WFID_W, recover_pc  in  PC_W: replay or recover redirect.
REQ-010 done_en  in  1, done_wfid  in  WFID_W: wavefront retire.
REQ-011 stop_fetch  in  NUM_WF: per-slot fetch inhibit.
REQ-012 req_valid  out  1, req_ready  in  1, req_addr  out  PC_W, req_tag  out  WFID_W+1 {epoch,wfid}: fetch request to the instruction buffer.
REQ-013 ack_valid  in  1, ack_wfid  in  WFID_W: the instruction buffer has completed one request.
REQ-014 vacant  out  NUM_WF: 1 = slot free.
REQ-015 free_valid  out  1, free_wfid  out  WFID_W: lowest-index vacant slot.
REQ-016 pending  out  NUM_WF: 1 = at least one request outstanding for the slot.

Function
REQ-017 Per-slot state: valid, pc, epoch, outstanding count; plus one round-robin pointer rr_ptr.
REQ-018 Eligibility: valid & ~stop_fetch & ~(done_en & done_wfid==i) & (count < MAXOUT).
REQ-019 Grant: first eligible slot scanning from rr_ptr upward, wrapping at NUM_WF-1 to 0; req_valid = any eligible.
REQ-020 Outputs are combinational from registered state and current inputs: req_addr = granted pc, req_tag = {epoch, granted wfid}.
REQ-021 Handshake: a transfer occurs when req_valid & req_ready; granted pc += FETCH_BYTES (mod 2^PC_W); count +1; rr_ptr = grant+1 (wraps to 0).
REQ-022 Without a transfer, rr_ptr holds; req_tag and req_addr may change while req_ready is low.
REQ-023 An ack decrements the count of ack_wfid; an ack when the count is 0 is ignored.
REQ-024 A transfer and an ack for the same slot in the same cycle leave the count unchanged.
REQ-025 init_wr: valid=1, pc=init_pc, epoch=0, count=0; init_wr to a non-vacant slot is ignored.
REQ-026 branch_en or recover_en to a valid slot: pc = redirect pc, epoch toggles, count unchanged; consumers discard acks carrying the old epoch.
REQ-027 Redirect to a vacant slot is ignored.
REQ-028 PC priority in one cycle on one slot: recover > branch > transfer increment; epoch toggles once only.
REQ-029 done_en: valid=0 next cycle; count is retained until acks drain it.
REQ-030 A slot reads vacant only when valid=0 and count=0; init_wr on a slot with count>0 is ignored.
REQ-031 done and init on the same wfid in the same cycle: done wins, init ignored.
REQ-032 free_valid=0 and free_wfid=0 when no slot is vacant.
REQ-033 wfid values >= NUM_WF on any input are ignored.

Reset
REQ-034 While rst=0, all slots are forced to valid=0, pc=0, epoch=0, count=0, and rr_ptr=0.
REQ-035 Reset values: req_valid=0, req_addr=0, req_tag=0, vacant all 1, pending all 0, free_valid=1, free_wfid=0.
REQ-036 Reset asserted mid-transfer drops the request; no later ack is expected.

Configuration
REQ-037 Macro WF_FETCH_DUAL_OUTSTANDING_EN defined: MAXOUT=2 and the count is 2 bits.
REQ-038 WF_FETCH_DUAL_OUTSTANDING_EN undefined: MAXOUT=1, the count is 1 bit, and a slot is ineligible while pending.

Verification
REQ-039 Reset, then init wfid 3 with pc 0x100, req_ready=1, then ack each cycle -> addrs 0x100, 0x120, 0x140; tag {0,3}.
REQ-040 Init slots 1, 5, 7; req_ready=1; ack each grant next cycle -> grant order 1, 5, 7, 1, and rr_ptr wraps.
REQ-041 Slot 2 pending at pc 0x220; branch to 0x800 -> epoch=1; next tag {1,2}, addr 0x800 after the ack.
REQ-042 Recover 0x400 and branch 0x500 on slot 4 in the same cycle as its transfer -> pc=0x400 and epoch toggles once.
REQ-043 Done on slot 6 with one request outstanding -> vacant[6]=0 until the ack, then 1; free_wfid=6 if it is the lowest vacant slot.
REQ-044 Macro defined, no acks, req_ready=1, single slot -> two transfers, then req_valid=0; undefined -> one transfer.
